calc_display_scan: RTL and testbench

- Downstream consumer of calc_top.
- Takes its eight parallel 7-segment patterns (displays[7:0]) and its status[1:0].
- Time-multiplexes them onto one shared active-low segment bus with active-low digit enables, as required by the board's common-anode 8-digit display.
- Snapshots the digit patterns once per scan frame to prevent tearing, and blinks the display while calc_top reports an error.

---
 rtl/calc_display_scan.sv | 115 +++++++++++
 tb/tb_calc_display_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan.sv
// Scans eight 7-segment patterns onto a shared active-low segment bus, one digit at a time,
// with per-frame snapshotting and error blink. Optional macro: LEADING_ZERO_BLANK_EN.
module calc_display_scan #(
    parameter int CLK_PER_DIGIT = 1000,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] displays [7:0],
    input  logic [1:0] status,
    input  logic       enable,
    output logic [7:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame_done
);
    localparam int PW = $clog2(CLK_PER_DIGIT);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_DIGIT - 1);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [6:0]    shadow_q [8];
    logic [6:0]    shadow_d [8];
    logic [7:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          frame_done_q, frame_done_d;
    logic          tick, boundary, blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0]    mask_q, mask_d, lead_mask;

    // A digit is a leading zero only if every digit above it is one too; digit 0 always shows.
    always_comb begin
        logic lead;
        lead      = 1'b1;
        lead_mask = '0;
        for (int i = 7; i >= 1; i--) begin
            lead         = lead && (displays[i] == 7'h3F);
            lead_mask[i] = lead;
        end
        mask_d = boundary ? lead_mask : mask_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mask_q <= '0;
        else        mask_q <= mask_d;
    end
`endif

    always_comb begin
        tick     = enable && (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == 3'd7);

        presc_d = presc_q;
        idx_d   = idx_q;
        if (enable) presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick)   idx_d   = idx_q + 3'd1;

        for (int i = 0; i < 8; i++) shadow_d[i] = boundary ? displays[i] : shadow_q[i];

        // Blink uses the status present on the boundary edge, so a same-edge change wins.
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (status != 2'b10) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (boundary) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Outputs are registered from next-state values so they move on the same edge as the index.
        blank        = !enable || phase_d;
        frame_done_d = boundary;
        an_n_d       = blank ? 8'hFF : ~(8'd1 << idx_d);
        seg_n_d      = blank ? 7'h7F : ~shadow_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
        if (mask_d[idx_d]) seg_n_d = 7'h7F;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
            an_n_q       <= 8'hFF;
            seg_n_q      <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            for (int i = 0; i < 8; i++) shadow_q[i] <= shadow_d[i];
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan: directed table, hand sequences and randomized traffic
// checked against a count-based reference model.
module tb_calc_display_scan;
    localparam int CPD   = 4;
    localparam int BF    = 2;
    localparam int FRAME = 8 * CPD;

    logic       clock;
    logic       reset;
    logic [6:0] disp [7:0];
    logic [1:0] status;
    logic       enable;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       frame_done;

    calc_display_scan #(.CLK_PER_DIGIT(CPD), .BLINK_FRAMES(BF)) dut (
        .clock(clock), .reset(reset), .displays(disp), .status(status),
        .enable(enable), .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: n counts enabled cycles since reset; digit, slot and frame follow by division.
    int         n;
    int         errf;
    logic [6:0] m_shadow [8];
    logic [7:0] m_mask;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    logic       m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        errf = 0;
        for (int i = 0; i < 8; i++) m_shadow[i] = 7'h00;
        m_mask  = 8'h00;
        m_phase = 1'b0;
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_fd  = 1'b0;
    endtask

    task automatic model_step();
        bit bnd;
        bit lead;
        int dig;
        bnd = 0;
        if (enable) begin
            n++;
            if (n % FRAME == 0) begin
                bnd = 1;
                for (int i = 0; i < 8; i++) m_shadow[i] = disp[i];
                m_mask = 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
                lead = 1;
                for (int d = 7; d >= 1; d--) begin
                    lead = lead && (disp[d] == 7'h3F);
                    m_mask[d] = lead;
                end
`endif
            end
        end
        if (status == 2'b10) begin
            if (bnd) errf++;
        end else begin
            errf = 0;
        end
        m_phase = ((errf / BF) % 2) == 1;
        dig     = (n / CPD) % 8;
        exp_fd  = bnd;
        if (!enable || m_phase) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            exp_an  = ~(8'd1 << dig);
            exp_seg = m_mask[dig] ? 7'h7F : ~m_shadow[dig];
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic cyc();
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step();
        #1;
        check("an_n", 32'(an_n), 32'(exp_an));
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic wait_pos(input int target);
        int k;
        k = 0;
        while ((n % FRAME) != target && k < 300) begin
            cyc();
            k++;
        end
        check("wait_pos_reached", 32'(n % FRAME), 32'(target));
    endtask

    typedef struct {
        int         adv;
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
    } vec_t;

    vec_t vt [13];
    int   cnt;

    initial begin
        vt[0]  = '{1, 8'hFE, 7'h7F, 1'b0};
        vt[1]  = '{2, 8'hFE, 7'h7F, 1'b0};
        vt[2]  = '{1, 8'hFD, 7'h7F, 1'b0};
        vt[3]  = '{3, 8'hFD, 7'h7F, 1'b0};
        vt[4]  = '{1, 8'hFB, 7'h7F, 1'b0};
        vt[5]  = '{4, 8'hF7, 7'h7F, 1'b0};
        vt[6]  = '{4, 8'hEF, 7'h7F, 1'b0};
        vt[7]  = '{4, 8'hDF, 7'h7F, 1'b0};
        vt[8]  = '{4, 8'hBF, 7'h7F, 1'b0};
        vt[9]  = '{4, 8'h7F, 7'h7F, 1'b0};
        vt[10] = '{4, 8'hFE, 7'h79, 1'b1};
        vt[11] = '{1, 8'hFE, 7'h79, 1'b0};
        vt[12] = '{3, 8'hFD, 7'h79, 1'b0};

        reset  = 1'b1;
        enable = 1'b1;
        status = 2'b00;
        for (int i = 0; i < 8; i++) disp[i] = 7'h06;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("reset_an", 32'(an_n), 32'hFF);
        check("reset_seg", 32'(seg_n), 32'h7F);
        repeat (3) cyc();
        reset = 1'b1;

        // Reset and scan table
        for (int v = 0; v < 13; v++) begin
            repeat (vt[v].adv) cyc();
            check("tbl_an", 32'(an_n), 32'(vt[v].an));
            check("tbl_seg", 32'(seg_n), 32'(vt[v].seg));
            check("tbl_fd", 32'(frame_done), 32'(vt[v].fd));
        end

        // Snapshot: change digit 3 while digit 5 is up; next digit-3 slot shows it
        wait_pos(20);
        disp[3] = 7'h5B;
        wait_pos(12);
        check("snapshot_seg", 32'(seg_n), 32'h24);

        // Error blink: two normal frames, two blank frames, then normal again
        wait_pos(0);
        status = 2'b10;
        repeat (63) cyc();
        check("blink_normal1", 32'(an_n == 8'hFF), 32'd0);
        cyc();
        check("blink_blank_an", 32'(an_n), 32'hFF);
        check("blink_blank_seg", 32'(seg_n), 32'h7F);
        repeat (63) cyc();
        check("blink_blank_end", 32'(an_n), 32'hFF);
        cyc();
        check("blink_normal2", 32'(an_n == 8'hFF), 32'd0);
        repeat (74) cyc();
        check("blink_blank_again", 32'(an_n), 32'hFF);
        status = 2'b00;
        cyc();
        check("blink_clear", 32'(an_n == 8'hFF), 32'd0);

        // Enable freeze mid digit 2, slot 1
        wait_pos(9);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("freeze_an", 32'(an_n), 32'hFF);
            check("freeze_fd", 32'(frame_done), 32'd0);
        end
        enable = 1'b1;
        cnt = 0;
        while (an_n !== 8'hF7 && cnt < 10) begin
            cyc();
            cnt++;
        end
        check("freeze_resume_cycles", 32'(cnt), 32'd3);

        // Async reset between edges while digit 6 is up
        wait_pos(24);
        #2 reset = 1'b0;
        #1;
        check("async_an", 32'(an_n), 32'hFF);
        check("async_seg", 32'(seg_n), 32'h7F);
        check("async_fd", 32'(frame_done), 32'd0);
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        check("restart_an", 32'(an_n), 32'hFE);

`ifdef LEADING_ZERO_BLANK_EN
        disp[7] = 7'h3F; disp[6] = 7'h3F; disp[5] = 7'h3F; disp[4] = 7'h3F;
        disp[3] = 7'h3F; disp[2] = 7'h06; disp[1] = 7'h3F; disp[0] = 7'h3F;
        wait_pos(0);
        check("lzb_d0", 32'(seg_n), 32'h40);
        wait_pos(4);
        check("lzb_d1", 32'(seg_n), 32'h40);
        wait_pos(8);
        check("lzb_d2", 32'(seg_n), 32'h79);
        wait_pos(12);
        check("lzb_d3", 32'(seg_n), 32'h7F);
        wait_pos(28);
        check("lzb_d7", 32'(seg_n), 32'h7F);
`endif

        // Randomized traffic against the model
        for (int seg = 0; seg < 20; seg++) begin
            status = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
            repeat ($urandom_range(100, 300)) begin
                if ($urandom_range(0, 19) == 0) enable = ~enable;
                if ($urandom_range(0, 9) == 0) disp[$urandom_range(0, 7)] = 7'($urandom);
                if ($urandom_range(0, 49) == 0) status = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 499) == 0) reset = 1'b0;
                else reset = 1'b1;
                cyc();
            end
        end
        reset  = 1'b1;
        enable = 1'b1;
        repeat (10) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
